// File: rtl/csi_frame_controller.sv
// Sequences one packet through the LTS-FFT -> equalizer -> CSI path: gates exactly
// NUM_LTS*FFT_LEN bins into the equalizer, frames CSI_LEN CSI beats, and aborts stalled packets.
module csi_frame_controller #(
   parameter int FFT_LEN = 64,
   parameter int NUM_LTS = 2,
   parameter int CSI_LEN = 52,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        enable_in,
   input  logic        trig_in,
   input  logic        s_fft_tvalid,
   input  logic        s_fft_tlast,
   input  logic [15:0] s_fft_re,
   input  logic [15:0] s_fft_im,
   output logic        s_fft_tready,
   output logic        m_eq_tvalid,
   output logic        m_eq_tlast,
   output logic [15:0] m_eq_re,
   output logic [15:0] m_eq_im,
   input  logic        m_eq_tready,
   output logic        eq_rst_out,
   input  logic        s_csi_tvalid,
   input  logic        s_csi_tlast,
   input  logic [15:0] s_csi_re,
   input  logic [15:0] s_csi_im,
   output logic        s_csi_tready,
   output logic        m_csi_tvalid,
   output logic        m_csi_tlast,
   output logic [15:0] m_csi_re,
   output logic [15:0] m_csi_im,
   input  logic        m_csi_tready,
   output logic        busy_out,
   output logic        frame_done_out,
   output logic        timeout_out,
   output logic [15:0] frame_cnt_out,
   output logic [15:0] drop_cnt_out
);

   localparam int IN_BEATS = FFT_LEN * NUM_LTS;
   localparam int IW = $clog2(IN_BEATS);
   localparam int OW = $clog2(CSI_LEN);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [IW-1:0] IN_LAST  = IW'(IN_BEATS - 1);
   localparam logic [OW-1:0] OUT_LAST = OW'(CSI_LEN - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, ABORT} state_e;

   state_e         state_q;
   logic [IW-1:0]  in_cnt_q;
   logic [OW-1:0]  out_cnt_q;
   logic [TW-1:0]  timer_q;
   logic           csi_done_q;
   logic           busy_q, frame_done_q, timeout_q, eq_rst_q;
   logic [15:0]    frame_cnt_q, drop_cnt_q;

   logic feed, active, csi_pass;
   logic eq_hs, csi_hs, in_last_hs, csi_last_hs;
   logic complete, abort, trig_drop;
   logic [1:0] drop_inc_d;

   // Upstream tlast is meaningless here: framing comes from our own counters.
   logic unused_tlast;
   assign unused_tlast = s_fft_tlast ^ s_csi_tlast;

   assign m_eq_re  = s_fft_re;
   assign m_eq_im  = s_fft_im;
   assign m_csi_re = s_csi_re;
   assign m_csi_im = s_csi_im;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      feed     = (state_q == FEED);
      active   = feed || (state_q == DRAIN);
      csi_pass = active && !csi_done_q;

      m_eq_tvalid  = 1'b0;
      m_eq_tlast   = 1'b0;
      s_fft_tready = 1'b1;
      if (feed) begin
         m_eq_tvalid  = s_fft_tvalid;
         m_eq_tlast   = (in_cnt_q == IN_LAST);
         s_fft_tready = m_eq_tready;
      end

      m_csi_tvalid = 1'b0;
      m_csi_tlast  = 1'b0;
      s_csi_tready = 1'b1;
      if (csi_pass) begin
         m_csi_tvalid = s_csi_tvalid;
         m_csi_tlast  = (out_cnt_q == OUT_LAST);
         s_csi_tready = m_csi_tready;
      end

      eq_hs       = m_eq_tvalid && m_eq_tready;
      csi_hs      = m_csi_tvalid && m_csi_tready;
      in_last_hs  = eq_hs && (in_cnt_q == IN_LAST);
      csi_last_hs = csi_hs && (out_cnt_q == OUT_LAST);
      // CSI may finish during LTS2; the frame then closes on the last FFT handshake.
      complete    = (feed && in_last_hs && (csi_done_q || csi_last_hs))
                 || ((state_q == DRAIN) && csi_last_hs);
      abort       = active && !eq_hs && !csi_hs && (timer_q == T_LAST);
      trig_drop   = trig_in && enable_in && (state_q != IDLE);
      drop_inc_d  = {1'b0, trig_drop} + {1'b0, abort};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q      <= IDLE;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         timer_q      <= '0;
         csi_done_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         eq_rst_q     <= 1'b1;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         eq_rst_q     <= 1'b0;
         drop_cnt_q   <= drop_cnt_q + {14'd0, drop_inc_d};
         case (state_q)
            IDLE: begin
               if (trig_in && enable_in) begin
                  state_q    <= FEED;
                  busy_q     <= 1'b1;
                  in_cnt_q   <= '0;
                  out_cnt_q  <= '0;
                  timer_q    <= '0;
                  csi_done_q <= 1'b0;
               end
            end
            FEED, DRAIN: begin
               if (eq_hs) in_cnt_q <= in_cnt_q + 1'b1;
               if (csi_hs) out_cnt_q <= out_cnt_q + 1'b1;
               if (csi_last_hs) csi_done_q <= 1'b1;
               if (eq_hs || csi_hs) timer_q <= '0;
               else timer_q <= timer_q + 1'b1;

               if (complete) begin
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
                  frame_cnt_q  <= frame_cnt_q + 16'd1;
               end else if (feed && in_last_hs) begin
                  state_q <= DRAIN;
               end else if (abort) begin
                  // Resetting the equalizer realigns its bin/LTS counters for the next packet.
                  state_q   <= ABORT;
                  timeout_q <= 1'b1;
                  eq_rst_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_out       = busy_q;
   assign frame_done_out = frame_done_q;
   assign timeout_out    = timeout_q;
   assign eq_rst_out     = eq_rst_q;
   assign frame_cnt_out  = frame_cnt_q;
   assign drop_cnt_out   = drop_cnt_q;

endmodule

// File: tb/tb_csi_frame_controller.sv
// Directed bench for csi_frame_controller: scoreboards both AXIS outputs and walks
// through framing, discards, drops, timeout abort, back-pressure and mid-frame reset.
module tb_csi_frame_controller;

   localparam int TO = 16;
   localparam int IN_BEATS = 128;
   localparam int CSI_N = 52;

   logic        clk_in = 1'b0;
   logic        rst_n_in, enable_in, trig_in;
   logic        s_fft_tvalid, s_fft_tlast, s_fft_tready;
   logic [15:0] s_fft_re, s_fft_im;
   logic        m_eq_tvalid, m_eq_tlast, m_eq_tready;
   logic [15:0] m_eq_re, m_eq_im;
   logic        eq_rst_out;
   logic        s_csi_tvalid, s_csi_tlast, s_csi_tready;
   logic [15:0] s_csi_re, s_csi_im;
   logic        m_csi_tvalid, m_csi_tlast, m_csi_tready;
   logic [15:0] m_csi_re, m_csi_im;
   logic        busy_out, frame_done_out, timeout_out;
   logic [15:0] frame_cnt_out, drop_cnt_out;

   int n_checks = 0;
   int n_errors = 0;
   logic [32:0] eq_q[$];
   logic [32:0] csi_q[$];

   always #5 clk_in = ~clk_in;

   csi_frame_controller #(.FFT_LEN(64), .NUM_LTS(2), .CSI_LEN(CSI_N), .TIMEOUT(TO)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in), .trig_in(trig_in),
      .s_fft_tvalid(s_fft_tvalid), .s_fft_tlast(s_fft_tlast), .s_fft_re(s_fft_re),
      .s_fft_im(s_fft_im), .s_fft_tready(s_fft_tready),
      .m_eq_tvalid(m_eq_tvalid), .m_eq_tlast(m_eq_tlast), .m_eq_re(m_eq_re),
      .m_eq_im(m_eq_im), .m_eq_tready(m_eq_tready), .eq_rst_out(eq_rst_out),
      .s_csi_tvalid(s_csi_tvalid), .s_csi_tlast(s_csi_tlast), .s_csi_re(s_csi_re),
      .s_csi_im(s_csi_im), .s_csi_tready(s_csi_tready),
      .m_csi_tvalid(m_csi_tvalid), .m_csi_tlast(m_csi_tlast), .m_csi_re(m_csi_re),
      .m_csi_im(m_csi_im), .m_csi_tready(m_csi_tready),
      .busy_out(busy_out), .frame_done_out(frame_done_out), .timeout_out(timeout_out),
      .frame_cnt_out(frame_cnt_out), .drop_cnt_out(drop_cnt_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Output side of the scoreboard: every handshake must match the oldest expected beat.
   always @(negedge clk_in) begin
      logic [32:0] exp;
      if (m_eq_tvalid && m_eq_tready) begin
         check("eq_sb_nonempty", 64'(eq_q.size() != 0), 64'(1));
         if (eq_q.size() != 0) begin
            exp = eq_q.pop_front();
            check("eq_beat", 64'({m_eq_tlast, m_eq_re, m_eq_im}), 64'(exp));
         end
      end
      if (m_csi_tvalid && m_csi_tready) begin
         check("csi_sb_nonempty", 64'(csi_q.size() != 0), 64'(1));
         if (csi_q.size() != 0) begin
            exp = csi_q.pop_front();
            check("csi_beat", 64'({m_csi_tlast, m_csi_re, m_csi_im}), 64'(exp));
         end
      end
   end

   // Trigger with a junk FFT beat on the same cycle; that beat must be discarded.
   task automatic do_trig();
      trig_in = 1'b1;
      s_fft_tvalid = 1'b1;
      s_fft_re = 16'h5a5a;
      s_fft_im = 16'ha5a5;
      @(negedge clk_in);
      check("trig_beat_m_eq_tvalid", 64'(m_eq_tvalid), 64'(0));
      check("trig_beat_s_fft_tready", 64'(s_fft_tready), 64'(1));
      step();
      trig_in = 1'b0;
      s_fft_tvalid = 1'b0;
      check("busy_after_trig", 64'(busy_out), 64'(1));
   endtask

   task automatic feed(input int n);
      for (int k = 0; k < n; k++) begin
         s_fft_tvalid = 1'b1;
         s_fft_tlast  = ((k % 64) == 63);
         s_fft_re     = 16'(k);
         s_fft_im     = 16'(-k);
         eq_q.push_back({k == IN_BEATS - 1, 16'(k), 16'(-k)});
         step();
      end
      s_fft_tvalid = 1'b0;
      s_fft_tlast  = 1'b0;
   endtask

   task automatic send_csi(input int n, input bit toggle, input int base);
      for (int i = 0; i < n; i++) begin
         bit hs;
         int tries;
         s_csi_tvalid = 1'b1;
         s_csi_tlast  = (i == 0);
         s_csi_re     = 16'(base + i);
         s_csi_im     = ~16'(base + i);
         csi_q.push_back({i == CSI_N - 1, 16'(base + i), ~16'(base + i)});
         hs = 1'b0;
         tries = 0;
         while (!hs && tries < 8) begin
            if (toggle) m_csi_tready = ~m_csi_tready;
            @(negedge clk_in);
            check("csi_ready_mirror", 64'(s_csi_tready), 64'(m_csi_tready));
            hs = s_csi_tready;
            step();
            tries++;
         end
         check("csi_beat_accepted", 64'(hs), 64'(1));
      end
      s_csi_tvalid = 1'b0;
      s_csi_tlast  = 1'b0;
      m_csi_tready = 1'b1;
   endtask

   initial begin
      rst_n_in = 1'b0; enable_in = 1'b1; trig_in = 1'b0;
      s_fft_tvalid = 1'b0; s_fft_tlast = 1'b0; s_fft_re = '0; s_fft_im = '0;
      s_csi_tvalid = 1'b0; s_csi_tlast = 1'b0; s_csi_re = '0; s_csi_im = '0;
      m_eq_tready = 1'b1; m_csi_tready = 1'b1;

      // Reset state and equalizer reset stretch.
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_eq_rst", 64'(eq_rst_out), 64'(1));
      check("rst_busy", 64'(busy_out), 64'(0));
      check("rst_frame_cnt", 64'(frame_cnt_out), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt_out), 64'(0));
      check("rst_frame_done", 64'(frame_done_out), 64'(0));
      check("rst_timeout", 64'(timeout_out), 64'(0));
      step();
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("rst_eq_rst_hold", 64'(eq_rst_out), 64'(1));
      step();
      check("rst_eq_rst_release", 64'(eq_rst_out), 64'(0));

      // Beats before the trigger are discarded.
      s_fft_tvalid = 1'b1; s_fft_re = 16'h7777; s_fft_im = 16'h1111;
      repeat (2) begin
         @(negedge clk_in);
         check("idle_s_fft_tready", 64'(s_fft_tready), 64'(1));
         check("idle_m_eq_tvalid", 64'(m_eq_tvalid), 64'(0));
         step();
      end

      // Basic frame: 128 bins in, 52 CSI beats out.
      do_trig();
      feed(IN_BEATS);
      check("drain_busy", 64'(busy_out), 64'(1));
      send_csi(CSI_N, 1'b0, 100);
      check("f1_done", 64'(frame_done_out), 64'(1));
      check("f1_frame_cnt", 64'(frame_cnt_out), 64'(1));
      check("f1_busy", 64'(busy_out), 64'(0));
      step();
      check("f1_done_pulse", 64'(frame_done_out), 64'(0));

      // CSI finishes during LTS2; extra CSI is discarded; frame closes on bin 127.
      do_trig();
      fork
         feed(IN_BEATS);
         begin
            repeat (10) step();
            send_csi(CSI_N, 1'b0, 300);
            s_csi_tvalid = 1'b1;
            repeat (3) begin
               @(negedge clk_in);
               check("extra_csi_tvalid", 64'(m_csi_tvalid), 64'(0));
               check("extra_csi_tready", 64'(s_csi_tready), 64'(1));
               step();
            end
            s_csi_tvalid = 1'b0;
            check("f2_not_yet_done", 64'(frame_cnt_out), 64'(1));
         end
      join
      check("f2_done", 64'(frame_done_out), 64'(1));
      check("f2_frame_cnt", 64'(frame_cnt_out), 64'(2));

      // Disabled trigger does nothing; trigger while busy is a drop.
      enable_in = 1'b0; trig_in = 1'b1;
      step();
      trig_in = 1'b0; enable_in = 1'b1;
      check("disabled_trig_busy", 64'(busy_out), 64'(0));
      check("disabled_trig_drop", 64'(drop_cnt_out), 64'(0));
      do_trig();
      feed(IN_BEATS);
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      check("busy_trig_drop", 64'(drop_cnt_out), 64'(1));
      enable_in = 1'b0; trig_in = 1'b1;
      step();
      trig_in = 1'b0; enable_in = 1'b1;
      check("busy_disabled_trig_drop", 64'(drop_cnt_out), 64'(1));
      check("busy_disabled_trig_busy", 64'(busy_out), 64'(1));
      send_csi(CSI_N, 1'b0, 500);
      check("f3_done", 64'(frame_done_out), 64'(1));
      check("f3_frame_cnt", 64'(frame_cnt_out), 64'(3));

      // Upstream stalls after 70 bins: abort after exactly TO idle cycles.
      do_trig();
      feed(70);
      repeat (TO - 1) step();
      check("to_not_yet", 64'(timeout_out), 64'(0));
      check("to_not_yet_busy", 64'(busy_out), 64'(1));
      step();
      check("to_pulse", 64'(timeout_out), 64'(1));
      check("to_eq_rst", 64'(eq_rst_out), 64'(1));
      check("to_drop_cnt", 64'(drop_cnt_out), 64'(2));
      step();
      check("to_pulse_end", 64'(timeout_out), 64'(0));
      check("to_eq_rst_end", 64'(eq_rst_out), 64'(0));
      check("to_busy_end", 64'(busy_out), 64'(0));
      do_trig();
      feed(IN_BEATS);
      send_csi(CSI_N, 1'b0, 700);
      check("f4_frame_cnt", 64'(frame_cnt_out), 64'(4));
      check("f4_drop_cnt", 64'(drop_cnt_out), 64'(2));

      // Downstream back-pressure toggling every cycle.
      do_trig();
      feed(IN_BEATS);
      send_csi(CSI_N, 1'b1, 900);
      check("f5_done", 64'(frame_done_out), 64'(1));
      check("f5_frame_cnt", 64'(frame_cnt_out), 64'(5));
      check("f5_no_abort", 64'(drop_cnt_out), 64'(2));

      // Reset in the middle of FEED.
      do_trig();
      feed(40);
      rst_n_in = 1'b0;
      step();
      s_fft_tvalid = 1'b1; s_fft_re = 16'h4444; s_fft_im = 16'h4444;
      @(negedge clk_in);
      check("mid_rst_busy", 64'(busy_out), 64'(0));
      check("mid_rst_frame_cnt", 64'(frame_cnt_out), 64'(0));
      check("mid_rst_drop_cnt", 64'(drop_cnt_out), 64'(0));
      check("mid_rst_eq_rst", 64'(eq_rst_out), 64'(1));
      check("mid_rst_m_eq_tvalid", 64'(m_eq_tvalid), 64'(0));
      check("mid_rst_s_fft_tready", 64'(s_fft_tready), 64'(1));
      step();
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("mid_rst_eq_rst_hold", 64'(eq_rst_out), 64'(1));
      step();
      s_fft_tvalid = 1'b0;
      check("mid_rst_eq_rst_release", 64'(eq_rst_out), 64'(0));
      do_trig();
      feed(IN_BEATS);
      send_csi(CSI_N, 1'b0, 1100);
      check("f6_frame_cnt", 64'(frame_cnt_out), 64'(1));
      check("f6_drop_cnt", 64'(drop_cnt_out), 64'(0));

      repeat (2) step();
      check("eq_sb_drained", 64'(eq_q.size()), 64'(0));
      check("csi_sb_drained", 64'(csi_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
